// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and configuration record for the multi-channel clock divider
package clk_div_pkg;
  localparam int DEF_CNT_W = 16;
  localparam int MIN_DIV = 2;
  typedef struct packed {
    logic [DEF_CNT_W-1:0] div;
    logic [DEF_CNT_W-1:0] high;
  } ch_cfg_t;
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel; new settings wait in a shadow and take effect only at a period start
module clk_div_ch #(
  parameter int CNT_W = clk_div_pkg::DEF_CNT_W,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clock_in,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_high,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pending
);
  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
  } cfg_t;
  localparam cfg_t RST_CFG = cfg_t'{CNT_W'(DEFAULT_DIV), CNT_W'(DEFAULT_DIV / 2)};
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  cfg_t r_act;
  cfg_t r_shd;
  cfg_t w_new;
  logic r_en_d;
  logic w_bnd;
  logic w_load;
  // a write landing on the boundary edge bypasses the shadow; a disabled channel loads at once
  always_comb begin
    w_cnt_nxt = (!r_en_d || r_cnt == r_act.div - 1'b1) ? '0 : r_cnt + 1'b1;
    w_bnd = w_cnt_nxt == '0;
    w_new = i_wr ? cfg_t'{i_div, i_high} : r_shd;
    w_load = i_en ? w_bnd && (i_wr || o_pending) : i_wr;
  end
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_act <= RST_CFG;
      r_shd <= RST_CFG;
      r_en_d <= 1'b0;
      o_clk <= 1'b0;
      o_tick <= 1'b0;
      o_pending <= 1'b0;
    end else begin
      r_en_d <= i_en;
      if (w_load) r_act <= w_new;
      if (i_wr) r_shd <= w_new;
      o_pending <= i_wr ? i_en && !w_bnd : o_pending && !(i_en && w_bnd);
      r_cnt <= i_en ? w_cnt_nxt : '0;
      o_clk <= i_en && (w_cnt_nxt < (w_load ? w_new.high : r_act.high));
      o_tick <= i_en && w_bnd;
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH glitch-free programmable clock dividers sharing one validated config port
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_DIV = 10,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);
  localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);
  logic w_ok;
  logic [CNT_W-1:0] w_high;
  assign w_ok = ({1'b0, cfg_ch} < NCH) && (cfg_div >= CNT_W'(MIN_DIV));
  assign w_high = (cfg_high >= cfg_div) ? cfg_div - 1'b1 : cfg_high;
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else cfg_err <= cfg_valid && !w_ok;
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(k);
    clk_div_ch #(
      .CNT_W(CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clock_in (clock_in),
      .rst_n    (rst_n),
      .i_en     (ch_en[k]),
      .i_wr     (cfg_valid && w_ok && cfg_ch == IDX),
      .i_div    (cfg_div),
      .i_high   (w_high),
      .o_clk    (clock_out[k]),
      .o_tick   (tick[k]),
      .o_pending(pending[k])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed checks of period, config shadowing, clamp, errors, enable and reset
module tb_clk_div_multi;
  logic clock_in = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] ch_en = '0;
  logic cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic [15:0] cfg_high = '0;
  logic cfg_err;
  logic [2:0] clock_out;
  logic [2:0] tick;
  logic [2:0] pending;
  int n_chk = 0;
  int n_fail = 0;

  clk_div_multi #(.NUM_CH(3), .CNT_W(16), .DEFAULT_DIV(10)) dut (
    .clock_in (clock_in),
    .rst_n    (rst_n),
    .ch_en    (ch_en),
    .cfg_valid(cfg_valid),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_err  (cfg_err),
    .clock_out(clock_out),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 clock_in = ~clock_in;

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] dv, input logic [15:0] hi);
    cfg_valid = 1'b1;
    cfg_ch = ch;
    cfg_div = dv;
    cfg_high = hi;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ch_en = 3'b111;
    cfg_write(2'd0, 16'd4, 16'd1);
    repeat (2) @(negedge clock_in);
    n_chk++;
    if ({clock_out, tick, pending, cfg_err} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_hold got %b want %b", {clock_out, tick, pending, cfg_err}, 10'b0);
    end
    cfg_valid = 1'b0;
    ch_en = '0;
    rst_n = 1'b1;
    @(negedge clock_in);
    n_chk++;
    if ({clock_out, tick, pending, cfg_err} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_release got %b want %b", {clock_out, tick, pending, cfg_err}, 10'b0);
    end
  endtask

  task automatic test_ch0_basic;
    logic [1:0] e;
    ch_en[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_in);
      e = {(i % 10) < 5, (i % 10) == 0};
      n_chk++;
      if ({clock_out[0], tick[0]} !== e) begin
        n_fail++;
        $display("FAIL ch0_period cyc %0d got %b want %b", i, {clock_out[0], tick[0]}, e);
      end
      n_chk++;
      if ({clock_out[2:1], tick[2:1], pending} !== 7'b0) begin
        n_fail++;
        $display("FAIL idle_channels cyc %0d got %b want 0", i, {clock_out[2:1], tick[2:1], pending});
      end
    end
  endtask

  task automatic test_pending;
    logic [2:0] e;
    ch_en[1] = 1'b1;
    repeat (3) @(negedge clock_in);
    cfg_write(2'd1, 16'd4, 16'd1);
    for (int k = 0; k < 19; k++) begin
      @(negedge clock_in);
      if (k == 0) begin
        cfg_valid = 1'b0;
        n_chk++;
        if (cfg_err !== 1'b0) begin
          n_fail++;
          $display("FAIL valid_write_err got %b want 0", cfg_err);
        end
      end
      e = (k < 7) ? {(3 + k) < 5, 1'b0, 1'b1} : {((k - 7) % 4) == 0, ((k - 7) % 4) == 0, 1'b0};
      n_chk++;
      if ({clock_out[1], tick[1], pending[1]} !== e) begin
        n_fail++;
        $display("FAIL ch1_shadow cyc %0d got %b want %b", k, {clock_out[1], tick[1], pending[1]}, e);
      end
    end
    cfg_write(2'd1, 16'd4, 16'd3);
    for (int j = 0; j < 5; j++) begin
      @(negedge clock_in);
      cfg_valid = 1'b0;
      e = {(j % 4) < 3, (j % 4) == 0, 1'b0};
      n_chk++;
      if ({clock_out[1], tick[1], pending[1]} !== e) begin
        n_fail++;
        $display("FAIL ch1_bypass cyc %0d got %b want %b", j, {clock_out[1], tick[1], pending[1]}, e);
      end
    end
  endtask

  task automatic test_cfg_err;
    logic [1:0] e;
    for (int w = 0; w < 2; w++) begin
      if (w == 0) cfg_write(2'd2, 16'd1, 16'd0);
      else cfg_write(2'd3, 16'd4, 16'd1);
      @(negedge clock_in);
      cfg_valid = 1'b0;
      n_chk++;
      if (cfg_err !== 1'b1) begin
        n_fail++;
        $display("FAIL cfg_err_pulse write %0d got %b want 1", w, cfg_err);
      end
      @(negedge clock_in);
      n_chk++;
      if ({cfg_err, pending[2]} !== 2'b00) begin
        n_fail++;
        $display("FAIL cfg_err_clear write %0d got %b want 00", w, {cfg_err, pending[2]});
      end
    end
    ch_en[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_in);
      e = {(i % 10) < 5, (i % 10) == 0};
      n_chk++;
      if ({clock_out[2], tick[2]} !== e) begin
        n_fail++;
        $display("FAIL ch2_unchanged cyc %0d got %b want %b", i, {clock_out[2], tick[2]}, e);
      end
    end
  endtask

  task automatic test_clamp;
    logic [1:0] e;
    ch_en[2] = 1'b0;
    @(negedge clock_in);
    cfg_write(2'd2, 16'd2, 16'd1);
    @(negedge clock_in);
    n_chk++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL min_div_accept got %b want 0", cfg_err);
    end
    cfg_write(2'd2, 16'd7, 16'd9);
    @(negedge clock_in);
    cfg_valid = 1'b0;
    n_chk++;
    if ({cfg_err, pending[2], clock_out[2]} !== 3'b000) begin
      n_fail++;
      $display("FAIL disabled_write got %b want 000", {cfg_err, pending[2], clock_out[2]});
    end
    ch_en[2] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock_in);
      e = {(i % 7) < 6, (i % 7) == 0};
      n_chk++;
      if ({clock_out[2], tick[2]} !== e) begin
        n_fail++;
        $display("FAIL clamp_high cyc %0d got %b want %b", i, {clock_out[2], tick[2]}, e);
      end
    end
    ch_en[2] = 1'b0;
    @(negedge clock_in);
    cfg_write(2'd2, 16'd7, 16'd0);
    @(negedge clock_in);
    cfg_valid = 1'b0;
    ch_en[2] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock_in);
      e = {1'b0, (i % 7) == 0};
      n_chk++;
      if ({clock_out[2], tick[2]} !== e) begin
        n_fail++;
        $display("FAIL zero_high cyc %0d got %b want %b", i, {clock_out[2], tick[2]}, e);
      end
    end
  endtask

  task automatic test_enable_drop;
    logic [1:0] e;
    ch_en[0] = 1'b0;
    @(negedge clock_in);
    ch_en[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock_in);
      e = {i < 5, i == 0};
      n_chk++;
      if ({clock_out[0], tick[0]} !== e) begin
        n_fail++;
        $display("FAIL pre_drop cyc %0d got %b want %b", i, {clock_out[0], tick[0]}, e);
      end
    end
    ch_en[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_in);
      n_chk++;
      if ({clock_out[0], tick[0]} !== 2'b00) begin
        n_fail++;
        $display("FAIL disabled cyc %0d got %b want 00", i, {clock_out[0], tick[0]});
      end
    end
    ch_en[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_in);
      e = {i < 5, i == 0};
      n_chk++;
      if ({clock_out[0], tick[0]} !== e) begin
        n_fail++;
        $display("FAIL re_enable cyc %0d got %b want %b", i, {clock_out[0], tick[0]}, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] c;
    repeat (3) @(negedge clock_in);
    cfg_write(2'd0, 16'd20, 16'd2);
    @(negedge clock_in);
    cfg_valid = 1'b0;
    n_chk++;
    if ({pending[0], clock_out[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_pending got %b want 11", {pending[0], clock_out[0]});
    end
    ch_en = 3'b011;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({clock_out, tick, pending, cfg_err} !== 10'b0) begin
      n_fail++;
      $display("FAIL async_reset got %b want %b", {clock_out, tick, pending, cfg_err}, 10'b0);
    end
    @(negedge clock_in);
    n_chk++;
    if ({clock_out, tick, pending, cfg_err} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_held got %b want %b", {clock_out, tick, pending, cfg_err}, 10'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_in);
      c = {2{(i % 10) < 5}};
      n_chk++;
      if ({clock_out, tick, pending} !== {1'b0, c, 1'b0, {2{(i % 10) == 0}}, 3'b000}) begin
        n_fail++;
        $display("FAIL defaults_restored cyc %0d got %b want %b", i, {clock_out, tick, pending},
                 {1'b0, c, 1'b0, {2{(i % 10) == 0}}, 3'b000});
      end
    end
  endtask

  initial begin
    test_reset();
    test_ch0_basic();
    test_pending();
    test_cfg_err();
    test_clamp();
    test_enable_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
